// File: rtl/c_lock_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-locking round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: lock FSM state encoding and the clogb width helper.
package c_lock_rr_arbiter_pkg;

  typedef enum logic {
    LOCK_ARB_STATE_IDLE   = 1'b0,
    LOCK_ARB_STATE_LOCKED = 1'b1
  } lock_arb_state_t;

  // Ceiling log2 with a floor of one bit, so a 1-entry index still has width.
  function automatic int clogb(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/c_lock_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Latency: n/a (wires only).
// Backpressure: grants are the only flow control; a port without gnt holds its flit.
// Signals: active, req_pr (level-major), tail, gnt_pr, gnt, locked, owner,
// and lock_abort when C_LOCK_ARB_IDLE_TIMEOUT_EN is defined.
interface c_lock_rr_arbiter_if #(
  parameter int num_ports      = 8,
  parameter int num_priorities = 1
);
  import c_lock_rr_arbiter_pkg::*;

  localparam int port_idx_width = clogb(num_ports);

  logic                                active;
  logic [num_priorities*num_ports-1:0] req_pr;
  logic [num_ports-1:0]                tail;
  logic [num_priorities*num_ports-1:0] gnt_pr;
  logic [num_ports-1:0]                gnt;
  logic                                locked;
  logic [port_idx_width-1:0]           owner;
`ifdef C_LOCK_ARB_IDLE_TIMEOUT_EN
  logic                                lock_abort;

  modport master (output active, req_pr, tail,
                  input  gnt_pr, gnt, locked, owner, lock_abort);
  modport slave  (input  active, req_pr, tail,
                  output gnt_pr, gnt, locked, owner, lock_abort);
`else
  modport master (output active, req_pr, tail,
                  input  gnt_pr, gnt, locked, owner);
  modport slave  (input  active, req_pr, tail,
                  output gnt_pr, gnt, locked, owner);
`endif

endinterface

// File: rtl/c_lock_rr_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; a request simply stays unpicked.
// Ports: req (vector), ptr (binary start) -> gnt (one-hot), idx (binary), any.
module c_rr_select #(
  parameter int num_ports = 8,
  parameter int idx_width = 3
) (
  input  logic [num_ports-1:0] req,
  input  logic [idx_width-1:0] ptr,
  output logic [num_ports-1:0] gnt,
  output logic [idx_width-1:0] idx,
  output logic                 any
);

  logic [idx_width-1:0] pos;

  // Scan offsets from farthest to nearest so the nearest requester is the
  // last assignment and therefore wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    any = |req;
    for (int k = num_ports - 1; k >= 0; k--) begin
      pos = idx_width'((int'(ptr) + k) % num_ports);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/c_lock_rr_arbiter.sv
// Round-robin arbiter that locks the resource to a port until its tail flit is granted.
// Latency: grants are combinational (zero cycles); state updates on the next clk edge.
// Backpressure: while locked only the owner can win; others are held off until release.
// Ports: clk, reset (sync, active-high), bus (c_lock_rr_arbiter_if.slave).
// Optional: C_LOCK_ARB_IDLE_TIMEOUT_EN adds an owner-idle watchdog and lock_abort.
module c_lock_rr_arbiter
  import c_lock_rr_arbiter_pkg::*;
#(
  parameter int num_ports      = 8,
  parameter int num_priorities = 1,
  parameter int max_idle       = 16
) (
  input logic                  clk,
  input logic                  reset,
  c_lock_rr_arbiter_if.slave   bus
);

  localparam int port_idx_width = clogb(num_ports);
  localparam int lvl_width      = clogb(num_priorities);

  if (num_ports < 2 || max_idle < 1) begin : g_bad_params
    $error("c_lock_rr_arbiter: num_ports must be >= 2 and max_idle >= 1");
  end

  lock_arb_state_t             state_q, state_d;
  logic [port_idx_width-1:0]   ptr_q, ptr_d;
  logic [port_idx_width-1:0]   owner_q, owner_d;

  logic [num_ports-1:0]        lvl_req [num_priorities];
  logic [num_ports-1:0]        lvl_gnt [num_priorities];
  logic [port_idx_width-1:0]   lvl_idx [num_priorities];
  logic [num_priorities-1:0]   lvl_any;
  logic [num_priorities-1:0]   own_req;
  logic [num_ports-1:0]        owner_oh;

  logic                        arb_en;
  logic                        abort;
  logic                        win_vld;
  logic [lvl_width-1:0]        win_lvl;
  logic [num_ports-1:0]        win_oh;
  logic [port_idx_width-1:0]   win_idx;

  function automatic logic [port_idx_width-1:0] next_port(input logic [port_idx_width-1:0] idx);
    return (int'(idx) == num_ports - 1) ? '0 : idx + 1'b1;
  endfunction

  for (genvar p = 0; p < num_priorities; p++) begin : g_lvl
    assign lvl_req[p] = bus.req_pr[p*num_ports +: num_ports];
    assign own_req[p] = lvl_req[p][owner_q];

    c_rr_select #(
      .num_ports (num_ports),
      .idx_width (port_idx_width)
    ) u_sel (
      .req (lvl_req[p]),
      .ptr (ptr_q),
      .gnt (lvl_gnt[p]),
      .idx (lvl_idx[p]),
      .any (lvl_any[p])
    );
  end

  assign owner_oh = num_ports'(1) << owner_q;

`ifdef C_LOCK_ARB_IDLE_TIMEOUT_EN
  localparam int cnt_width = clogb(max_idle + 1);
  logic [cnt_width-1:0] idle_cnt_q, idle_cnt_d;

  // The abort cycle is the one in which the counter already sits at max_idle.
  assign abort = !reset && bus.active && (state_q == LOCK_ARB_STATE_LOCKED) &&
                 (idle_cnt_q == cnt_width'(max_idle));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    // Any grant either serves the owner or enters LOCKED; both restart the count.
    if (win_vld || abort) begin
      idle_cnt_d = '0;
    end else if (bus.active && (state_q == LOCK_ARB_STATE_LOCKED) &&
                 (idle_cnt_q != cnt_width'(max_idle))) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign arb_en = bus.active && !reset && !abort;

  // Winner selection; lowest level wins because it is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_lvl = '0;
    win_oh  = '0;
    win_idx = '0;
    if (arb_en) begin
      for (int p = num_priorities - 1; p >= 0; p--) begin
        if (state_q == LOCK_ARB_STATE_LOCKED) begin
          if (own_req[p]) begin
            win_vld = 1'b1;
            win_lvl = lvl_width'(p);
            win_oh  = owner_oh;
            win_idx = owner_q;
          end
        end else if (lvl_any[p]) begin
          win_vld = 1'b1;
          win_lvl = lvl_width'(p);
          win_oh  = lvl_gnt[p];
          win_idx = lvl_idx[p];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCK_ARB_STATE_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Next state; the pointer only advances when a packet completes or is aborted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (abort) begin
      state_d = LOCK_ARB_STATE_IDLE;
      ptr_d   = next_port(owner_q);
    end else if (win_vld) begin
      if (bus.tail[win_idx]) begin
        state_d = LOCK_ARB_STATE_IDLE;
        ptr_d   = next_port(win_idx);
      end else begin
        state_d = LOCK_ARB_STATE_LOCKED;
        owner_d = win_idx;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.gnt_pr = '0;
    bus.gnt    = win_oh;
    for (int p = 0; p < num_priorities; p++) begin
      if (win_vld && (int'(win_lvl) == p)) bus.gnt_pr[p*num_ports +: num_ports] = win_oh;
    end
    bus.locked = (state_q == LOCK_ARB_STATE_LOCKED);
    bus.owner  = owner_q;
`ifdef C_LOCK_ARB_IDLE_TIMEOUT_EN
    bus.lock_abort = abort;
`endif
  end

  a_no_req_inactive: assert property (@(posedge clk) disable iff (reset)
    !bus.active |-> (bus.req_pr == '0));

endmodule
